serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor that computes diff = a - b - bin. It uses one full-subtractor cell and processes one bit per clock, LSB first, with a registered borrow chain. It is the subtract-direction counterpart of the adder datapath. It sits between a valid/ready producer and a valid/ready consumer, and trades latency for area in arithmetic paths.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b and bin are valid
in_ready  output  1  block can accept an operation (high only in IDLE)
a  input  WIDTH  minuend, unsigned or two's complement
b  input  WIDTH  subtrahend
bin  input  1  borrow-in
out_valid  output  1  result valid; held until accepted
out_ready  input  1  consumer accepts the result
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  final borrow-out (unsigned underflow)
ovf  output  1  signed overflow of a - b - bin
busy  output  1  operation in flight (SHIFT or DONE)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset, applied at any time including mid-operation:
  - state = IDLE.
  - out_valid, bout, ovf, busy = 0; diff = 0.
  - Shift registers, borrow register and bit counter = 0.
  - in_ready = 1, decoded from IDLE.
  - Inputs are ignored while rst_n is low.
  - An in-flight operation is discarded with no partial result.
- FSM IDLE -> SHIFT:
  - On in_valid && in_ready, latch a and b into shift registers, set borrow register = bin, counter = 0.
  - The a and b inputs may change freely after the accepting edge.
- FSM SHIFT, each cycle:
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d is shifted into the MSB of the diff register; the diff register shifts right.
  - The a and b shift registers shift right.
  - Counter increments.
  - Transition to DONE on the edge processing bit WIDTH-1.
- FSM DONE:
  - out_valid = 1.
  - bout = final borrow.
  - ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using latched copies of the original operand MSBs.
  - On out_valid && out_ready, go to IDLE; out_valid falls on that edge.
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles minimum.
- No same-cycle accept while in DONE: in_ready stays 0 until IDLE is re-entered.
- Backpressure: while out_valid && !out_ready, diff, bout and ovf stay stable and the state holds.
- Output validity:
  - diff, bout and ovf are guaranteed only while out_valid = 1.
  - diff may change during SHIFT.
  - After the handshake, all three retain the last result until the next load.
- in_valid outside IDLE is ignored; no operand is captured.
- busy = (state != IDLE).
- WIDTH = 1: SHIFT lasts one cycle; ovf uses bit 0 as the sign bit.
- bin = 1 with a = b gives diff = all ones and bout = 1.

Test Plan:
- Unsigned subtract: WIDTH=8, a=200, b=55, bin=0 -> diff=145, bout=0, ovf=0. out_valid rises 8 edges after accept.
- Underflow: a=5, b=10, bin=0 -> diff=8'hFB (251), bout=1, ovf=0.
- Signed overflow: a=8'h80, b=8'h01, bin=0 -> diff=8'h7F, bout=0, ovf=1.
- Borrow-in: a=0, b=0, bin=1 -> diff=8'hFF, bout=1, ovf=0.
- Backpressure and ignored input:
  - Hold out_ready=0 for 5 cycles after out_valid.
  - diff, bout and ovf stay stable; in_ready=0; an in_valid pulse with a=1, b=1 is not captured.
  - After the handshake, in_ready=1 on the next cycle.
- Reset mid-SHIFT:
  - Assert rst_n=0 asynchronously during the 3rd shift cycle.
  - out_valid=0 and busy=0 immediately; in_ready=1.
  - After release, a=8'h3C, b=8'h0F gives diff=8'h2D, bout=0, with no residue from the aborted operation.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin: one full-subtractor cell, LSB first,
// registered borrow, valid/ready on both sides.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sr, b_sr, diff_sr, diff_shift;
  logic [CW-1:0]    cnt;
  logic             br, br_nx, d;
  logic             a_msb, b_msb;
  logic             load, step;

  assign d     = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nx = (~a_sr[0] & b_sr[0])
               | (~(a_sr[0] ^ b_sr[0]) & br);

  // New bit enters at the MSB; result ends LSB-aligned after WIDTH steps
  generate
    if (WIDTH == 1) begin : g_w1
      assign diff_shift = d;
    end else begin : g_wn
      assign diff_shift = {d, diff_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == LAST) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      br      <= 1'b0;
      cnt     <= '0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b;
      br    <= bin;
      cnt   <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (step) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      diff_sr <= diff_shift;
      br      <= br_nx;
      cnt     <= cnt + 1'b1;
    end
  end

  assign diff = diff_sr;
  assign bout = br;
  assign ovf  = (a_msb ^ b_msb) & (diff_sr[WIDTH-1] ^ a_msb);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: arithmetic reference
// model, queued expectations, negedge monitor.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [W+1:0] exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .ovf      (ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // {ovf, bout, diff} from plain integer arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c);
    longint u, s, lo, hi;
    logic [W+1:0] r;
    u  = longint'(x) - longint'(y) - longint'(c);
    s  = longint'($signed(x)) - longint'($signed(y)) - longint'(c);
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    r[W-1:0] = u[W-1:0];
    r[W]     = (u < 0);
    r[W+1]   = (s < lo) || (s > hi);
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input bit rnd);
    int k = 0;
    while (!in_ready && k < 300) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: in_ready stuck 0 at %0t", $time);
      return;
    end
    a        = x;
    b        = y;
    bin      = c;
    in_valid = 1'b1;
    exp_q.push_back(model(x, y, c));
    step();
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    bin      = 1'($urandom);
  endtask

  task automatic wait_lat();
    int lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    check("latency", 64'(lat), 64'(W));
  endtask

  task automatic drain();
    int k = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || !in_ready) && k < 300) begin
      step();
      k++;
    end
    if (exp_q.size() != 0 || !in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results pending", exp_q.size());
    end
  endtask

  task automatic monitor();
    logic [W+1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: diff %0h with empty queue", diff);
        end else begin
          e = exp_q.pop_front();
          check("diff", 64'(diff), 64'(e[W-1:0]));
          check("bout", 64'(bout), 64'(e[W]));
          check("ovf", 64'(ovf), 64'(e[W+1]));
        end
      end
    end
  endtask

  logic [W-1:0] da [4] = '{8'd200, 8'd5, 8'h80, 8'h00};
  logic [W-1:0] db [4] = '{8'd55, 8'd10, 8'h01, 8'h00};
  logic         dc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [W+1:0] e;
    fork
      monitor();
    join_none

    in_valid = 1'b1;
    a = 8'h11;
    b = 8'h22;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_diff", 64'(diff), 64'd0);
    check("rst_bout", 64'(bout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    step();
    check("rst_ignore_busy", 64'(busy), 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      issue(da[i], db[i], dc[i], 1'b0);
      wait_lat();
      drain();
    end

    out_ready = 1'b0;
    issue(8'hA5, 8'h5A, 1'b1, 1'b0);
    e = model(8'hA5, 8'h5A, 1'b1);
    wait_lat();
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_diff", 64'(diff), 64'(e[W-1:0]));
      check("bp_bout", 64'(bout), 64'(e[W]));
      check("bp_ovf", 64'(ovf), 64'(e[W+1]));
      in_valid = (i == 1);
      a = 8'h01;
      b = 8'h01;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("hs_in_ready", 64'(in_ready), 64'd1);
    check("hs_out_valid", 64'(out_valid), 64'd0);
    check("hs_diff_kept", 64'(diff), 64'(e[W-1:0]));
    step();
    check("hs_no_capture", 64'(busy), 64'd0);

    issue(8'h77, 8'h11, 1'b0, 1'b0);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_diff", 64'(diff), 64'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    issue(8'h3C, 8'h0F, 1'b0, 1'b0);
    wait_lat();
    drain();

    for (int i = 0; i < 60; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    end
    drain();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
